reset_modport: RTL and testbench

RESET_MODPORT -- requirements
Module: reset_modport

---
 rtl/reset_modport_if.sv | 26 ++
 rtl/reset_modport.sv | 108 ++++++++++
 tb/tb_reset_modport.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reset_modport_if.sv
// Bundle between a reset-pulse requester/observer and the reset_modport block:
// master-side request and drive, plus passive monitor results.
interface reset_modport_if #(
  parameter int unsigned CNT_W = 16
);
  logic             req;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic             reset_n_o;
  logic             reset_n_i;
  logic             mon_asserted;
  logic             mon_fall;
  logic             mon_rise;
  logic [CNT_W-1:0] mon_pulse_len;
  logic [15:0]      mon_count;

  modport master (
    output req, len, reset_n_i,
    input  busy, reset_n_o, mon_asserted, mon_fall, mon_rise, mon_pulse_len, mon_count
  );

  modport slave (
    input  req, len, reset_n_i,
    output busy, reset_n_o, mon_asserted, mon_fall, mon_rise, mon_pulse_len, mon_count
  );
endinterface

// File: rtl/reset_modport.sv
// Reset pulse generator (master) plus an independent reset-line monitor that
// measures low-pulse length and counts completed pulses.
module reset_modport #(
  parameter int unsigned PULSE_CYCLES = 5,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  reset_modport_if.slave      bus
);

  localparam logic [0:0]       IDLE       = 1'b0;
  localparam logic [0:0]       ASSERT     = 1'b1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] LEN_MAX    = {CNT_W{1'b1}};
  localparam logic [15:0]      COUNT_MAX  = 16'hFFFF;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;
  logic             rst_n_q;

  // Master state register; busy and the reset drive are flops fed from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ASSERT;
      cnt_q   <= PULSE_LOAD;
      busy_q  <= 1'b1;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ASSERT);
      rst_n_q <= (state_d == IDLE);
    end
  end

  // Requests arriving during ASSERT are dropped; the pulse ends after cnt cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = ASSERT;
          cnt_d   = (bus.len == '0) ? PULSE_LOAD : bus.len;
        end
      end
      ASSERT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.reset_n_o = rst_n_q;

  logic             s1_q, s2_q;
  logic             fall_c, rise_c;
  logic [CNT_W-1:0] low_cnt_q;
  logic [CNT_W-1:0] pulse_len_q;
  logic [15:0]      count_q;

  assign fall_c = s2_q & ~s1_q;
  assign rise_c = ~s2_q & s1_q;

  // Monitor: two-stage sample of reset_n_i, low-length measurement, pulse count.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      low_cnt_q   <= '0;
      pulse_len_q <= '0;
      count_q     <= '0;
    end else begin
      s1_q <= bus.reset_n_i;
      s2_q <= s1_q;
      // The fall cycle itself is the first low cycle, hence restart at 1.
      if (fall_c) begin
        low_cnt_q <= CNT_W'(1);
      end else if (!s1_q && (low_cnt_q != LEN_MAX)) begin
        low_cnt_q <= low_cnt_q + CNT_W'(1);
      end
      if (rise_c) begin
        pulse_len_q <= low_cnt_q;
        if (count_q != COUNT_MAX) begin
          count_q <= count_q + 16'd1;
        end
      end
    end
  end

  assign bus.mon_asserted  = ~s1_q;
  assign bus.mon_fall      = fall_c;
  assign bus.mon_rise      = rise_c;
  assign bus.mon_pulse_len = pulse_len_q;
  assign bus.mon_count     = count_q;

endmodule

// File: tb/tb_reset_modport.sv
// Directed bench for reset_modport: power-on pulse, loopback measurement,
// default length, ignored requests, glitches, simultaneous events, mid-pulse reset.
module tb_reset_modport;

  logic clk;
  logic reset;
  logic tie;
  logic drv_n;
  int   checks;
  int   failures;
  int   exp_count;
  int   fall_seen;
  int   rise_seen;

  reset_modport_if #(.CNT_W(16)) bus ();

  reset_modport #(.PULSE_CYCLES(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.reset_n_i = tie ? bus.reset_n_o : drv_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.mon_fall === 1'b1) fall_seen = fall_seen + 1;
    if (bus.mon_rise === 1'b1) rise_seen = rise_seen + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Counts consecutive negedge samples with reset_n_o low, starting now.
  task automatic count_low(output int n);
    n = 0;
    while (bus.reset_n_o === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_req(input logic [15:0] l);
    bus.req = 1'b1;
    bus.len = l;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.req = 1'b0; bus.len = '0; tie = 1'b0; drv_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.reset_n_o !== 1'b0) begin failures++; $display("FAIL rst_reset_n_o got=%b exp=0", bus.reset_n_o); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.mon_count !== 16'd0) begin failures++; $display("FAIL rst_mon_count got=%0d exp=0", bus.mon_count); end
    checks++; if (bus.mon_pulse_len !== 16'd0) begin failures++; $display("FAIL rst_pulse_len got=%0d exp=0", bus.mon_pulse_len); end
    checks++; if ({bus.mon_asserted, bus.mon_fall, bus.mon_rise} !== 3'b000) begin
      failures++; $display("FAIL rst_mon_flags got=%b exp=000", {bus.mon_asserted, bus.mon_fall, bus.mon_rise}); end
  endtask

  task automatic test_power_on;
    int n;
    reset = 1'b0;
    count_low(n);
    checks++; if (n != 5) begin failures++; $display("FAIL power_on_len got=%0d exp=5", n); end
    checks++; if (bus.busy !== 1'b0 || bus.reset_n_o !== 1'b1) begin
      failures++; $display("FAIL power_on_end busy=%b reset_n_o=%b exp busy=0 reset_n_o=1", bus.busy, bus.reset_n_o); end
    repeat (4) @(negedge clk);
    checks++; if (bus.reset_n_o !== 1'b1) begin failures++; $display("FAIL power_on_stay got=%b exp=1", bus.reset_n_o); end
  endtask

  task automatic test_loopback;
    int n;
    tie = 1'b1;
    fall_seen = 0; rise_seen = 0;
    pulse_req(16'd8);
    count_low(n);
    checks++; if (n != 8) begin failures++; $display("FAIL loop_len got=%0d exp=8", n); end
    repeat (2) @(negedge clk);
    exp_count++;
    checks++; if (bus.mon_pulse_len !== 16'd8) begin failures++; $display("FAIL loop_pulse_len got=%0d exp=8", bus.mon_pulse_len); end
    checks++; if (bus.mon_count !== 16'(exp_count)) begin failures++; $display("FAIL loop_count got=%0d exp=%0d", bus.mon_count, exp_count); end
    checks++; if (fall_seen != 1 || rise_seen != 1) begin
      failures++; $display("FAIL loop_edges fall=%0d rise=%0d exp 1 and 1", fall_seen, rise_seen); end
    checks++; if (bus.mon_asserted !== 1'b0) begin failures++; $display("FAIL loop_asserted got=%b exp=0", bus.mon_asserted); end
  endtask

  task automatic test_default_len;
    int n;
    pulse_req(16'd0);
    count_low(n);
    checks++; if (n != 5) begin failures++; $display("FAIL default_len got=%0d exp=5", n); end
    repeat (2) @(negedge clk);
    exp_count++;
    checks++; if (bus.mon_pulse_len !== 16'd5) begin failures++; $display("FAIL default_pulse_len got=%0d exp=5", bus.mon_pulse_len); end
    checks++; if (bus.mon_count !== 16'(exp_count)) begin failures++; $display("FAIL default_count got=%0d exp=%0d", bus.mon_count, exp_count); end
  endtask

  task automatic test_ignored_req;
    int n;
    pulse_req(16'd10);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.reset_n_o === 1'b0) n++;
      if (i == 2) begin bus.req = 1'b1; bus.len = 16'd3; end
      if (i == 3) bus.req = 1'b0;
      @(negedge clk);
    end
    checks++; if (n != 10) begin failures++; $display("FAIL ignored_total_low got=%0d exp=10", n); end
    exp_count++;
    checks++; if (bus.mon_pulse_len !== 16'd10) begin failures++; $display("FAIL ignored_pulse_len got=%0d exp=10", bus.mon_pulse_len); end
    checks++; if (bus.mon_count !== 16'(exp_count)) begin failures++; $display("FAIL ignored_count got=%0d exp=%0d", bus.mon_count, exp_count); end
  endtask

  task automatic test_glitch;
    tie = 1'b0; drv_n = 1'b1;
    @(negedge clk);
    drv_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.mon_fall !== 1'b1 || bus.mon_asserted !== 1'b1) begin
      failures++; $display("FAIL glitch_fall fall=%b asserted=%b exp 1 and 1", bus.mon_fall, bus.mon_asserted); end
    drv_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_count++;
    checks++; if (bus.mon_pulse_len !== 16'd1) begin failures++; $display("FAIL glitch1_len got=%0d exp=1", bus.mon_pulse_len); end
    checks++; if (bus.mon_count !== 16'(exp_count)) begin failures++; $display("FAIL glitch1_count got=%0d exp=%0d", bus.mon_count, exp_count); end
    drv_n = 1'b0;
    repeat (2) @(negedge clk);
    drv_n = 1'b1;
    repeat (4) @(negedge clk);
    exp_count++;
    checks++; if (bus.mon_pulse_len !== 16'd2) begin failures++; $display("FAIL glitch2_len got=%0d exp=2", bus.mon_pulse_len); end
    checks++; if (bus.mon_count !== 16'(exp_count)) begin failures++; $display("FAIL glitch2_count got=%0d exp=%0d", bus.mon_count, exp_count); end
  endtask

  task automatic test_simultaneous;
    int n;
    bus.req = 1'b1; bus.len = 16'd4; drv_n = 1'b0;
    @(negedge clk);
    bus.req = 1'b0; drv_n = 1'b1;
    count_low(n);
    checks++; if (n != 4) begin failures++; $display("FAIL simul_master_len got=%0d exp=4", n); end
    repeat (3) @(negedge clk);
    exp_count++;
    checks++; if (bus.mon_pulse_len !== 16'd1) begin failures++; $display("FAIL simul_mon_len got=%0d exp=1", bus.mon_pulse_len); end
    checks++; if (bus.mon_count !== 16'(exp_count)) begin failures++; $display("FAIL simul_count got=%0d exp=%0d", bus.mon_count, exp_count); end
  endtask

  task automatic test_mid_reset;
    int n;
    tie = 1'b1;
    pulse_req(16'd20);
    repeat (5) @(negedge clk);
    checks++; if (bus.reset_n_o !== 1'b0) begin failures++; $display("FAIL mid_in_pulse got=%b exp=0", bus.reset_n_o); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.mon_count !== 16'd0 || bus.mon_pulse_len !== 16'd0) begin
      failures++; $display("FAIL mid_rst_mon count=%0d len=%0d exp 0 and 0", bus.mon_count, bus.mon_pulse_len); end
    checks++; if (bus.busy !== 1'b1 || bus.mon_asserted !== 1'b0) begin
      failures++; $display("FAIL mid_rst_state busy=%b asserted=%b exp 1 and 0", bus.busy, bus.mon_asserted); end
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    count_low(n);
    checks++; if (n != 5) begin failures++; $display("FAIL mid_power_on_len got=%0d exp=5", n); end
    checks++; if (bus.mon_count !== 16'd0) begin failures++; $display("FAIL mid_count_cleared got=%0d exp=0", bus.mon_count); end
    repeat (2) @(negedge clk);
    exp_count++;
    checks++; if (bus.mon_count !== 16'(exp_count) || bus.mon_pulse_len !== 16'd5) begin
      failures++; $display("FAIL mid_after count=%0d len=%0d exp %0d and 5", bus.mon_count, bus.mon_pulse_len, exp_count); end
  endtask

  initial begin
    checks = 0; failures = 0; exp_count = 0; fall_seen = 0; rise_seen = 0;
    test_reset();
    test_power_on();
    test_loopback();
    test_default_len();
    test_ignored_req();
    test_glitch();
    test_simultaneous();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
